// File: rtl/traffic_conflict_monitor.sv
// Safety stage between the signal controller and the lamp drivers: passes the light vectors
// through one register stage and locks into flashing red on conflicts, bad encodings or stuck lamps.
module traffic_conflict_monitor #(
  parameter int MAX_GREEN     = 60,
  parameter int MAX_RED       = 180,
  parameter int FAULT_CONFIRM = 2,
  parameter int FLASH_HALF    = 1,
  parameter int ALL_RED_HOLD  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] north_light_in,
  input  logic [2:0] west_light_in,
  input  logic [2:0] south_light_in,
  input  logic [2:0] east_light_in,
  input  logic       fault_clr,
  output logic [2:0] north_light,
  output logic [2:0] west_light,
  output logic [2:0] south_light,
  output logic [2:0] east_light,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int HOLD_W  = $clog2(MAX_RED + 2);
  localparam int CONF_W  = $clog2(FAULT_CONFIRM + 1);
  localparam int FLASH_W = $clog2(FLASH_HALF + 1);
  localparam int REC_W   = $clog2(ALL_RED_HOLD + 1);

  localparam logic [2:0]        RED      = 3'b100;
  localparam logic [2:0]        YELLOW   = 3'b010;
  localparam logic [2:0]        GREEN    = 3'b001;
  localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(MAX_RED + 1);

  typedef enum logic [1:0] {
    S_PASS,
    S_CONFIRM,
    S_FAILSAFE,
    S_RECOVER
  } state_e;

  typedef enum logic [2:0] {
    CODE_NONE        = 3'b000,
    CODE_CONFLICT    = 3'b001,
    CODE_INVALID     = 3'b010,
    CODE_GY_TIMEOUT  = 3'b011,
    CODE_RED_TIMEOUT = 3'b100
  } code_e;

  // Direction index: 0 north, 1 west, 2 south, 3 east.
  logic [3:0][2:0] light_in;
  assign light_in = {east_light_in, south_light_in, west_light_in, north_light_in};

  state_e                   state_q, state_d;
  code_e                    code_q, code_d;
  logic [3:0][2:0]          lamps_q, lamps_d;
  logic [3:0][2:0]          prev_q;
  logic [3:0][HOLD_W-1:0]   hold_q, hold_d;
  logic [CONF_W-1:0]        confirm_q, confirm_d;
  logic [FLASH_W-1:0]       flash_q, flash_d;
  logic [REC_W-1:0]         rec_q, rec_d;

  logic [3:0] nonred, legal, gy_hit, red_hit;
  code_e      viol_code;
  logic       violation;
  logic       all_red_in;

  // NOTE: every signal driven in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    hold_d  = hold_q;
    nonred  = '0;
    legal   = '0;
    gy_hit  = '0;
    red_hit = '0;
    for (int d = 0; d < 4; d++) begin
      if (state_q == S_RECOVER) begin
        hold_d[d] = '0;
      end else if (light_in[d] != prev_q[d]) begin
        hold_d[d] = HOLD_W'(1);
      end else if (hold_q[d] != HOLD_SAT) begin
        hold_d[d] = hold_q[d] + HOLD_W'(1);
      end
      nonred[d]  = (light_in[d] != RED);
      legal[d]   = (light_in[d] == RED) || (light_in[d] == YELLOW) || (light_in[d] == GREEN);
      // The timeout test uses the count including this sample, so a value change never times out.
      gy_hit[d]  = nonred[d] && (int'(hold_d[d]) > MAX_GREEN);
      red_hit[d] = !nonred[d] && (int'(hold_d[d]) > MAX_RED);
    end
  end

  always_comb begin
    viol_code = CODE_NONE;
    if ((nonred[0] | nonred[2]) & (nonred[1] | nonred[3])) begin
      viol_code = CODE_CONFLICT;
    end else if (!(&legal)) begin
      viol_code = CODE_INVALID;
    end else if (|gy_hit) begin
      viol_code = CODE_GY_TIMEOUT;
    end else if (|red_hit) begin
      viol_code = CODE_RED_TIMEOUT;
    end
  end

  assign violation  = (viol_code != CODE_NONE);
  assign all_red_in = (light_in == {4{RED}});

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    confirm_d = confirm_q;
    flash_d   = flash_q;
    rec_d     = rec_q;
    lamps_d   = {4{RED}};

    unique case (state_q)
      S_PASS: begin
        if (violation) begin
          confirm_d = CONF_W'(1);
          if (FAULT_CONFIRM <= 1) begin
            state_d = S_FAILSAFE;
            code_d  = viol_code;
            flash_d = FLASH_W'(1);
          end else begin
            state_d = S_CONFIRM;
          end
        end else begin
          lamps_d = light_in;
        end
      end

      S_CONFIRM: begin
        if (violation) begin
          if (int'(confirm_q) + 1 >= FAULT_CONFIRM) begin
            state_d = S_FAILSAFE;
            code_d  = viol_code;
            flash_d = FLASH_W'(1);
          end else begin
            confirm_d = confirm_q + CONF_W'(1);
          end
        end else begin
          state_d = S_PASS;
          lamps_d = light_in;
        end
      end

      S_FAILSAFE: begin
        if (fault_clr && all_red_in) begin
          state_d = S_RECOVER;
          code_d  = CODE_NONE;
          rec_d   = '0;
        end else if (flash_q == FLASH_W'(FLASH_HALF)) begin
          flash_d = FLASH_W'(1);
          lamps_d = (lamps_q[0] == RED) ? '0 : {4{RED}};
        end else begin
          flash_d = flash_q + FLASH_W'(1);
          lamps_d = lamps_q;
        end
      end

      S_RECOVER: begin
        if (rec_q == REC_W'(ALL_RED_HOLD - 1)) begin
          state_d = S_PASS;
        end else begin
          rec_d = rec_q + REC_W'(1);
        end
      end

      default: state_d = S_RECOVER;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_RECOVER;
      code_q    <= CODE_NONE;
      lamps_q   <= {4{RED}};
      prev_q    <= {4{RED}};
      hold_q    <= '0;
      confirm_q <= '0;
      flash_q   <= '0;
      rec_q     <= '0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      lamps_q   <= lamps_d;
      prev_q    <= light_in;
      hold_q    <= hold_d;
      confirm_q <= confirm_d;
      flash_q   <= flash_d;
      rec_q     <= rec_d;
    end
  end

  assign north_light = lamps_q[0];
  assign west_light  = lamps_q[1];
  assign south_light = lamps_q[2];
  assign east_light  = lamps_q[3];
  assign fault       = (state_q == S_FAILSAFE);
  assign fault_code  = code_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Scoreboard bench for traffic_conflict_monitor: directed scenarios plus random traffic phases,
// checked against a cycle-level behavioural model of the safety rules.
module tb_traffic_conflict_monitor;

  localparam int MAX_GREEN     = 60;
  localparam int MAX_RED       = 180;
  localparam int FAULT_CONFIRM = 2;
  localparam int FLASH_HALF    = 1;
  localparam int ALL_RED_HOLD  = 3;

  localparam logic [2:0] RED  = 3'b100;
  localparam logic [2:0] YEL  = 3'b010;
  localparam logic [2:0] GRN  = 3'b001;

  localparam int M_PASS = 0, M_CONF = 1, M_FS = 2, M_REC = 3;

  typedef struct packed {
    logic [11:0] lamps;
    logic        fault;
    logic [2:0]  code;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] n_in = GRN, w_in = RED, s_in = GRN, e_in = RED;
  logic       clr = 1'b0;
  logic [2:0] n_out, w_out, s_out, e_out;
  logic       fault;
  logic [2:0] fault_code;

  int total = 0;
  int bad   = 0;

  exp_t exp_q[$];

  // Reference model state: run lengths are plain unbounded integers.
  int         m_mode = M_REC;
  int         m_run[4];
  logic [2:0] m_last[4];
  int         m_streak, m_fs_age, m_rec_age;
  logic [2:0] m_code;

  traffic_conflict_monitor dut (
    .clk            (clk),
    .rst            (rst),
    .north_light_in (n_in),
    .west_light_in  (w_in),
    .south_light_in (s_in),
    .east_light_in  (e_in),
    .fault_clr      (clr),
    .north_light    (n_out),
    .west_light     (w_out),
    .south_light    (s_out),
    .east_light     (e_out),
    .fault          (fault),
    .fault_code     (fault_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] rule_code(input logic [2:0] v[4]);
    bit ns_go, ew_go, invalid, gy, rd;
    ns_go   = (v[0] != RED) || (v[2] != RED);
    ew_go   = (v[1] != RED) || (v[3] != RED);
    invalid = 0;
    gy      = 0;
    rd      = 0;
    for (int d = 0; d < 4; d++) begin
      if (!(v[d] inside {RED, YEL, GRN})) invalid = 1;
      if (v[d] != RED && m_run[d] > MAX_GREEN) gy = 1;
      if (v[d] == RED && m_run[d] > MAX_RED) rd = 1;
    end
    if (ns_go && ew_go) return 3'b001;
    if (invalid)        return 3'b010;
    if (gy)             return 3'b011;
    if (rd)             return 3'b100;
    return 3'b000;
  endfunction

  task automatic model_step(input logic [2:0] n, w, s, e, input logic c);
    logic [2:0]  v[4];
    logic [11:0] lamps;
    logic [2:0]  code;
    exp_t        x;
    v[0] = n; v[1] = w; v[2] = s; v[3] = e;
    lamps = {4{RED}};
    if (m_mode == M_REC) begin
      m_rec_age++;
      for (int d = 0; d < 4; d++) begin
        m_run[d]  = 0;
        m_last[d] = v[d];
      end
      if (m_rec_age >= ALL_RED_HOLD) m_mode = M_PASS;
    end else begin
      for (int d = 0; d < 4; d++) begin
        m_run[d]  = (v[d] == m_last[d]) ? m_run[d] + 1 : 1;
        m_last[d] = v[d];
      end
      code = rule_code(v);
      if (m_mode == M_FS) begin
        if (c && n == RED && w == RED && s == RED && e == RED) begin
          m_mode    = M_REC;
          m_rec_age = 0;
        end else begin
          m_fs_age++;
          lamps = (((m_fs_age / FLASH_HALF) % 2) == 0) ? {4{RED}} : 12'h000;
        end
      end else if (code != 3'b000) begin
        m_streak = (m_mode == M_PASS) ? 1 : m_streak + 1;
        if (m_streak >= FAULT_CONFIRM) begin
          m_mode   = M_FS;
          m_code   = code;
          m_fs_age = 0;
        end else begin
          m_mode = M_CONF;
        end
      end else begin
        m_mode = M_PASS;
        lamps  = {n, w, s, e};
      end
    end
    x.lamps = lamps;
    x.fault = (m_mode == M_FS);
    x.code  = (m_mode == M_FS) ? m_code : 3'b000;
    exp_q.push_back(x);
  endtask

  task automatic tick(input logic [2:0] n, w, s, e, input logic c);
    @(negedge clk);
    rst  = 1'b1;
    n_in = n; w_in = w; s_in = s; e_in = e;
    clr  = c;
    model_step(n, w, s, e, c);
  endtask

  task automatic hold(input int cycles, input logic [2:0] n, w, s, e);
    for (int i = 0; i < cycles; i++) tick(n, w, s, e, 1'b0);
  endtask

  task automatic expect_now(input string name, input logic f, input logic [2:0] code);
    @(posedge clk);
    #1;
    check({name, "_fault"}, {11'b0, fault}, {11'b0, f});
    check({name, "_code"}, {9'b0, fault_code}, {9'b0, code});
  endtask

  task automatic clear_fault(input bit bogus_first);
    if (bogus_first) tick(GRN, RED, GRN, RED, 1'b1);
    tick(RED, RED, RED, RED, 1'b0);
    tick(RED, RED, RED, RED, 1'b1);
    hold(ALL_RED_HOLD + 1, RED, RED, RED, RED);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_lamps"}, {n_out, w_out, s_out, e_out}, {4{RED}});
    check({name, "_fault"}, {11'b0, fault}, 12'h000);
    check({name, "_code"}, {9'b0, fault_code}, 12'h000);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    rst = 1'b0;
    m_mode    = M_REC;
    m_rec_age = 0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    #1;
    check_reset_outputs("reset_held");
  endtask

  // Monitor: every clock edge with reset released presents one registered output word.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (rst && exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("lamps", {n_out, w_out, s_out, e_out}, x.lamps);
        check("fault", {11'b0, fault}, {11'b0, x.fault});
        check("code", {9'b0, fault_code}, {9'b0, x.code});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [2:0] go, bad_v, dir_v[4];
    int glen, ylen, len;

    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_reset_outputs("power_on_reset");

    // Reset release: all-red hold, then one-cycle pass-through.
    hold(8, GRN, RED, GRN, RED);

    // Single-cycle conflict.
    tick(GRN, RED, RED, GRN, 1'b0);
    hold(4, RED, GRN, RED, GRN);
    expect_now("single_conflict", 1'b0, 3'b000);

    // Two-cycle conflict, flash, ignored clear, accepted clear.
    hold(2, GRN, RED, RED, GRN);
    hold(3, GRN, RED, RED, RED);
    tick(GRN, RED, RED, RED, 1'b1);
    expect_now("conflict_fault", 1'b1, 3'b001);
    clear_fault(1'b0);
    hold(3, GRN, RED, GRN, RED);
    expect_now("after_clear", 1'b0, 3'b000);

    // Invalid encoding, then invalid plus conflict.
    hold(2, RED, 3'b011, RED, RED);
    expect_now("invalid", 1'b1, 3'b010);
    clear_fault(1'b0);
    hold(2, GRN, 3'b011, RED, GRN);
    expect_now("invalid_conflict", 1'b1, 3'b001);
    clear_fault(1'b0);

    // Green held exactly MAX_GREEN, then yellow: no fault.
    tick(RED, GRN, RED, GRN, 1'b0);
    hold(MAX_GREEN, GRN, RED, GRN, RED);
    hold(3, YEL, RED, YEL, RED);
    expect_now("green_at_limit", 1'b0, 3'b000);

    // Green held MAX_GREEN+2: timeout fault.
    tick(RED, GRN, RED, GRN, 1'b0);
    hold(MAX_GREEN + 2, GRN, RED, GRN, RED);
    expect_now("green_timeout", 1'b1, 3'b011);
    hold(2, GRN, RED, GRN, RED);
    clear_fault(1'b1);

    // All red beyond MAX_RED: starvation fault.
    hold(MAX_RED + 2, RED, RED, RED, RED);
    expect_now("red_timeout", 1'b1, 3'b100);
    clear_fault(1'b0);

    // Reset during failsafe flash.
    hold(2, GRN, GRN, RED, RED);
    hold(3, GRN, RED, GRN, RED);
    mid_reset();
    hold(6, RED, GRN, RED, GRN);

    // Random controller-like traffic with injected faults.
    for (int p = 0; p < 30; p++) begin
      go   = ($urandom_range(0, 1) == 0) ? GRN : RED;
      glen = $urandom_range(2, 68);
      ylen = $urandom_range(1, 3);
      dir_v[0] = go;  dir_v[2] = go;
      dir_v[1] = (go == GRN) ? RED : GRN;
      dir_v[3] = dir_v[1];
      hold(glen, dir_v[0], dir_v[1], dir_v[2], dir_v[3]);
      if ($urandom_range(0, 2) == 0) begin
        len = $urandom_range(1, 3);
        if ($urandom_range(0, 1) == 0) begin
          hold(len, GRN, YEL, GRN, GRN);
        end else begin
          do bad_v = 3'($urandom_range(0, 7)); while (bad_v inside {RED, YEL, GRN});
          dir_v[$urandom_range(0, 3)] = bad_v;
          hold(len, dir_v[0], dir_v[1], dir_v[2], dir_v[3]);
        end
      end
      for (int d = 0; d < 4; d++) if (dir_v[d] != RED) dir_v[d] = YEL;
      hold(ylen, dir_v[0], dir_v[1], dir_v[2], dir_v[3]);
      hold($urandom_range(1, 2), RED, RED, RED, RED);
      if (m_mode == M_FS) clear_fault($urandom_range(0, 1) == 1);
    end

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 12'(exp_q.size()), 12'h000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
